bank_write_ctrl: RTL and testbench

Write-side sequencer for the two ping-pong spectrogram memory banks drained by the serial readout FSM. Each incoming spectrogram frame gets a write slot in the active bank. The block swaps banks when one fills and locks each filled or partially filled bank until the readout releases it. It generates the bank0_full, bank1_full, memorization_completed and idx_final handshake consumed by the readout side.

---
 rtl/bank_write_ctrl.sv | 142 ++++++++++++++
 tb/tb_bank_write_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_write_ctrl.sv
// Write-side sequencer for the ping-pong spectrogram banks. Assigns each incoming frame a
// slot in the active bank, swaps banks on fill, locks filled or partially filled banks until
// the readout releases them, and raises the full/completion handshake for the readout side.
module bank_write_ctrl #(
  parameter int unsigned DEPTH  = 200,
  parameter int unsigned AW     = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              event_active,
  input  logic              frame_valid,
  input  logic [1:0]        bank_read_done,
  output logic              we,
  output logic [AW:0]       waddr,
  output logic              bank0_full,
  output logic              bank1_full,
  output logic              memorization_completed,
  output logic [AW-1:0]     idx_final,
  output logic              wr_bank,
  output logic              busy,
  output logic              overflow,
  output logic [DROP_W-1:0] dropped_frames
);

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StWaitFree} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic                bank_q, bank_d;
  logic [1:0]          lock_q, lock_set;
  logic [1:0]          full_q, full_d;
  logic                done_q, done_d;
  logic [AW-1:0]       idx_final_q, idx_final_d;
  logic                ovf_q;
  logic [DROP_W-1:0]   drop_q;
  logic                drop_inc;
  logic [AW-1:0]       idx_post;

  // Next-state, bank/slot bookkeeping and write strobe.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bank_d      = bank_q;
    lock_set    = 2'b00;
    full_d      = 2'b00;
    done_d      = 1'b0;
    idx_final_d = idx_final_q;
    drop_inc    = 1'b0;
    we          = 1'b0;
    idx_post    = idx_q + AW'(frame_valid);
    unique case (state_q)
      StIdle: begin
        if (event_active) begin
          if (!lock_q[bank_q]) begin
            state_d = StWrite;
            idx_d   = '0;
          end else begin
            state_d = StWaitFree;
          end
        end
      end
      StWrite: begin
        we = frame_valid;
        if (frame_valid && idx_q == LastIdx) begin
          // Bank filled: the full pulse takes precedence over any same-cycle event end.
          full_d[bank_q]   = 1'b1;
          lock_set[bank_q] = 1'b1;
          bank_d           = ~bank_q;
          idx_d            = '0;
          if (!event_active) begin
            state_d = StIdle;
          end else if (lock_q[~bank_q] && !bank_read_done[~bank_q]) begin
            state_d = StWaitFree;
          end
        end else begin
          idx_d = idx_post;
          if (!event_active) begin
            state_d = StIdle;
            idx_d   = '0;
            if (idx_post != '0) begin
              done_d           = 1'b1;
              idx_final_d      = idx_post - AW'(1);
              lock_set[bank_q] = 1'b1;
              bank_d           = ~bank_q;
            end
          end
        end
      end
      StWaitFree: begin
        drop_inc = frame_valid;
        if (!event_active) begin
          state_d = StIdle;
        end else if (!lock_q[bank_q] || bank_read_done[bank_q]) begin
          state_d = StWrite;
          idx_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, lock and status registers; lock set wins over a same-cycle release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      bank_q      <= 1'b0;
      lock_q      <= 2'b00;
      full_q      <= 2'b00;
      done_q      <= 1'b0;
      idx_final_q <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bank_q      <= bank_d;
      lock_q      <= (lock_q & ~bank_read_done) | lock_set;
      full_q      <= full_d;
      done_q      <= done_d;
      idx_final_q <= idx_final_d;
      ovf_q       <= ovf_q | drop_inc;
      if (drop_inc && drop_q != '1) begin
        drop_q <= drop_q + DROP_W'(1);
      end
    end
  end

  assign waddr                  = {bank_q, idx_q};
  assign bank0_full             = full_q[0];
  assign bank1_full             = full_q[1];
  assign memorization_completed = done_q;
  assign idx_final              = idx_final_q;
  assign wr_bank                = bank_q;
  assign busy                   = (state_q != StIdle);
  assign overflow               = ovf_q;
  assign dropped_frames         = drop_q;

endmodule

// File: tb/tb_bank_write_ctrl.sv
// Self-checking bench for bank_write_ctrl: table of whole-event scenarios plus hand-written
// sequences for release/resume, simultaneous end-and-fill and reset mid-write.
module tb_bank_write_ctrl;
  localparam int DEPTH = 200;
  localparam int AW = 8;
  localparam int DROP_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              event_active = 1'b0;
  logic              frame_valid = 1'b0;
  logic [1:0]        bank_read_done = 2'b00;
  logic              we;
  logic [AW:0]       waddr;
  logic              bank0_full, bank1_full, memorization_completed;
  logic [AW-1:0]     idx_final;
  logic              wr_bank, busy, overflow;
  logic [DROP_W-1:0] dropped_frames;

  bank_write_ctrl #(.DEPTH(DEPTH), .AW(AW), .DROP_W(DROP_W)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .event_active           (event_active),
    .frame_valid            (frame_valid),
    .bank_read_done         (bank_read_done),
    .we                     (we),
    .waddr                  (waddr),
    .bank0_full             (bank0_full),
    .bank1_full             (bank1_full),
    .memorization_completed (memorization_completed),
    .idx_final              (idx_final),
    .wr_bank                (wr_bank),
    .busy                   (busy),
    .overflow               (overflow),
    .dropped_frames         (dropped_frames)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [AW:0] addr;
  } exp_t;

  typedef struct {
    int n;      // frames sent back-to-back
    bit rel;    // pulse bank_read_done[0] 10 cycles after bank0_full
    int b0;
    int b1;
    int mc;
    int idxf;
    int wrb;
    int drop;
    int ovf;
  } vec_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int b0_cnt = 0, b1_cnt = 0, mc_cnt = 0;
  int s0, s1, sm;
  vec_t vecs[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sample this cycle at the falling edge, then move to 1 ns after the next rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      if (bank0_full || bank1_full || memorization_completed) begin
        chk("pulse_exclusive", 32'(bank0_full) + 32'(bank1_full) + 32'(memorization_completed),
            32'd1);
      end
      b0_cnt += int'(bank0_full);
      b1_cnt += int'(bank1_full);
      mc_cnt += int'(memorization_completed);
      if (frame_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: frame with no expected entry (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("we", 32'(we), 32'(e.we));
          if (e.we) chk("waddr", 32'(waddr), 32'(e.addr));
        end
      end else begin
        chk("idle_we", 32'(we), 32'd0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    event_active   = 1'b0;
    frame_valid    = 1'b0;
    bank_read_done = 2'b00;
    reset          = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic w, input int bank, input int idx);
    exp_t e;
    e.we   = w;
    e.addr = (AW + 1)'(bank * (1 << AW) + idx);
    sb.push_back(e);
  endtask

  task automatic send_frames(input int n, input int bank);
    for (int k = 0; k < n; k++) begin
      frame_valid = 1'b1;
      push(1'b1, bank, k);
      cycle();
    end
    frame_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bit wr;
    do_reset();
    s0 = b0_cnt; s1 = b1_cnt; sm = mc_cnt;
    event_active = 1'b1;
    cycle();
    for (int k = 0; k < v.n; k++) begin
      frame_valid    = 1'b1;
      bank_read_done = (v.rel && k == DEPTH + 10) ? 2'b01 : 2'b00;
      wr = (k < 2 * DEPTH) || v.rel;
      push(wr, (k / DEPTH) % 2, k % DEPTH);
      cycle();
    end
    frame_valid    = 1'b0;
    bank_read_done = 2'b00;
    event_active   = 1'b0;
    cycle();
    chk("mc_latency", 32'(memorization_completed), 32'(v.mc));
    cycle();
    cycle();
    chk("b0_pulses", 32'(b0_cnt - s0), 32'(v.b0));
    chk("b1_pulses", 32'(b1_cnt - s1), 32'(v.b1));
    chk("mc_pulses", 32'(mc_cnt - sm), 32'(v.mc));
    chk("idx_final", 32'(idx_final), 32'(v.idxf));
    chk("wr_bank", 32'(wr_bank), 32'(v.wrb));
    chk("dropped", 32'(dropped_frames), 32'(v.drop));
    chk("overflow", 32'(overflow), 32'(v.ovf));
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    //          n    rel  b0 b1 mc idxf wrb drop ovf
    vecs[0] = '{50,  1'b0, 0, 0, 1, 49, 1, 0,  0};
    vecs[1] = '{250, 1'b1, 1, 0, 1, 49, 0, 0,  0};
    vecs[2] = '{450, 1'b0, 1, 1, 0, 0,  0, 50, 1};

    do_reset();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_pulses", {29'd0, bank0_full, bank1_full, memorization_completed}, 32'd0);
    chk("rst_status", {28'd0, wr_bank, busy, overflow, 1'b0}, 32'd0);
    chk("rst_idxf_drop", {16'd0, 8'(idx_final), 8'(dropped_frames)}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Continue from the overflow scenario: bank 0 locked, release resumes writing at 0x000.
    event_active = 1'b1;
    cycle();
    frame_valid = 1'b1;
    push(1'b0, 0, 0);
    cycle();
    chk("wait_busy", 32'(busy), 32'd1);
    frame_valid    = 1'b0;
    bank_read_done = 2'b01;
    cycle();
    bank_read_done = 2'b00;
    send_frames(3, 0);
    event_active = 1'b0;
    cycle();
    chk("resume_mc", 32'(memorization_completed), 32'd1);
    chk("resume_idxf", 32'(idx_final), 32'd2);
    chk("resume_drop", 32'(dropped_frames), 32'd51);
    chk("resume_bank", 32'(wr_bank), 32'd1);

    // Fill and event end in the same cycle: full pulse only, idx_final untouched.
    do_reset();
    event_active = 1'b1;
    cycle();
    send_frames(10, 0);
    event_active = 1'b0;
    cycle();
    bank_read_done = 2'b01;
    cycle();
    bank_read_done = 2'b00;
    event_active   = 1'b1;
    cycle();
    send_frames(10, 1);
    event_active = 1'b0;
    cycle();
    cycle();
    chk("pre_idxf", 32'(idx_final), 32'd9);
    chk("pre_bank", 32'(wr_bank), 32'd0);
    event_active = 1'b1;
    cycle();
    send_frames(DEPTH - 1, 0);
    frame_valid  = 1'b1;
    event_active = 1'b0;
    push(1'b1, 0, DEPTH - 1);
    s0 = b0_cnt; sm = mc_cnt;
    cycle();
    frame_valid = 1'b0;
    chk("sim_b0_full", 32'(bank0_full), 32'd1);
    chk("sim_no_mc", 32'(memorization_completed), 32'd0);
    cycle();
    cycle();
    chk("sim_mc_cnt", 32'(mc_cnt - sm), 32'd0);
    chk("sim_idxf", 32'(idx_final), 32'd9);
    chk("sim_bank", 32'(wr_bank), 32'd1);
    chk("sim_busy", 32'(busy), 32'd0);

    // Reset mid-write aborts immediately and restarts cleanly at 0x000.
    do_reset();
    event_active = 1'b1;
    cycle();
    send_frames(30, 0);
    cycle();
    s0 = b0_cnt; s1 = b1_cnt; sm = mc_cnt;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_we_addr", {22'd0, we, waddr}, 32'd0);
    chk("mid_rst_busy_bank", {30'd0, busy, wr_bank}, 32'd0);
    chk("mid_rst_pulses", {29'd0, bank0_full, bank1_full, memorization_completed}, 32'd0);
    event_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cycle();
    cycle();
    chk("post_rst_pulses", 32'((b0_cnt - s0) + (b1_cnt - s1) + (mc_cnt - sm)), 32'd0);
    event_active = 1'b1;
    cycle();
    send_frames(1, 0);
    event_active = 1'b0;
    cycle();
    chk("post_rst_mc", 32'(memorization_completed), 32'd1);
    chk("post_rst_idxf", 32'(idx_final), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
